// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_pkg
//  Description : Shared types for the parametrised register file. Holds the
//                clear-sequencer state encoding used by the sequencer and top.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_file_pkg;

    // CLEAR: array is being swept to zero, writes refused.
    // RUN  : normal operation.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_t;

endpackage : reg_file_pkg
`default_nettype wire

// File: rtl/reg_file_clr_seq.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_clr_seq
//  Description : Post-reset clear sequencer. Walks a pointer from 0 to
//                DEPTH-1, requesting a zero write at each address, then
//                parks in RUN until the next reset.
//  Ports       : clk        - system clock
//                i_rst      - synchronous active-high reset
//                o_busy     - clear sweep in progress
//                o_clr_we   - zero-write request for the array this cycle
//                o_clr_addr - address to be zeroed
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file_clr_seq
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              i_rst,
    output logic              o_busy,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr
);

    // Last address of the sweep; comparing against it (rather than waiting
    // for the pointer to wrap) keeps the pointer at ADDR_W bits.
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = '1;

    rf_state_t         r_state;
    rf_state_t         w_state_nxt;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [ADDR_W-1:0] w_clr_ptr_nxt;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state   <= CLEAR;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_ptr <= w_clr_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_ptr_nxt = r_clr_ptr;
        case (r_state)
            CLEAR: begin
                if (r_clr_ptr == c_LAST_ADDR) begin
                    w_state_nxt = RUN;
                end else begin
                    w_clr_ptr_nxt = r_clr_ptr + 1'b1;
                end
            end
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = CLEAR;
        endcase
    end

    assign o_busy     = (r_state == CLEAR);
    // Reset edges must leave the array alone, so the zero write is held off
    // while reset is asserted.
    assign o_clr_we   = o_busy & ~i_rst;
    assign o_clr_addr = r_clr_ptr;

endmodule : reg_file_clr_seq
`default_nettype wire

// File: rtl/reg_file_param.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_param
//  Description : Parametrised 2-read / 1-write register file with a hardware
//                clear sweep after reset, optional write-to-read bypass and
//                optional hardwired-zero register 0.
//  Ports       : clk                  - system clock
//                reset                - synchronous active-high reset
//                write/wr_addr/wr_data - write port
//                rd_addr_a/rd_data_a  - A read port (combinational)
//                rd_addr_b/rd_data_b  - B read port (combinational)
//                busy                 - clear sweep running, writes refused
//                wr_err               - 1-cycle pulse, a write was refused
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              busy,
    output logic              wr_err
);

    localparam int c_DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic              r_wr_err;
    logic              w_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_zero_wr;
    logic              w_wr_en;

    reg_file_clr_seq #(
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk        (clk),
        .i_rst      (reset),
        .o_busy     (w_busy),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    // Writes aimed at a hardwired-zero register 0 are silently discarded.
    generate
        if (ZERO_REG != 0) begin : g_zero_reg
            assign w_zero_wr = (wr_addr == '0);
        end else begin : g_no_zero_reg
            assign w_zero_wr = 1'b0;
        end
    endgenerate

    // Busy already excludes the sweep, so user and clear writes never collide.
    assign w_wr_en = write & ~w_busy & ~w_zero_wr & ~reset;

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= write & w_busy;
        end
    end

    // Read resolution, evaluated per port: busy and zero-reg force zero,
    // then a same-cycle write to the same address wins when bypass is on.
    function automatic logic [DATA_W-1:0] f_read(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] data;
        data = r_mem[addr];
        if (w_busy) begin
            data = '0;
        end else if ((ZERO_REG != 0) && (addr == '0)) begin
            data = '0;
        end else if ((BYPASS != 0) && write && (addr == wr_addr)) begin
            data = wr_data;
        end
        return data;
    endfunction

    always_comb rd_data_a = f_read(rd_addr_a);
    always_comb rd_data_b = f_read(rd_addr_b);

    assign busy   = w_busy;
    assign wr_err = r_wr_err;

endmodule : reg_file_param
`default_nettype wire
